// File: rtl/uart16550_nasti_master.sv
// NASTI-lite master acting as a 16550 driver: programs divisor and LCR
// after reset, then writes each streamed byte to THR once LSR.THRE is set.
module uart16550_nasti_master #(
   parameter logic [15:0] DIVISOR   = 16'hadde,
   parameter logic [7:0]  LCR_VALUE = 8'h03,
   parameter int unsigned POLL_MAX  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       init_done,
   output logic       busy,
   output logic       err,
   output logic [2:0] aw_addr,
   output logic       aw_valid,
   input  logic       aw_ready,
   output logic [7:0] w_data,
   output logic       w_valid,
   input  logic       w_ready,
   input  logic [1:0] b_resp,
   input  logic       b_valid,
   output logic       b_ready,
   output logic [2:0] ar_addr,
   output logic       ar_valid,
   input  logic       ar_ready,
   input  logic [1:0] r_resp,
   input  logic [7:0] r_data,
   input  logic       r_valid,
   output logic       r_ready
);
   localparam logic [15:0] PMAX = 16'(POLL_MAX);
   localparam bit UNLIMITED = (POLL_MAX == 0);

   typedef enum logic [3:0] {
      INIT0, INIT1, INIT2, INIT3, IDLE,
      POLL_AR, POLL_R, WR_REQ, WR_RESP
   } state_t;

   state_t      state, state_n, ret, ret_n;
   logic        run, aw_done, w_done, req, err_set;
   logic [2:0]  req_addr;
   logic [7:0]  req_data, tx_byte;
   logic [15:0] poll_cnt, poll_inc;
   logic        unused;

   assign unused   = ^{r_data[7:6], r_data[4:0]};
   assign ar_addr  = 3'd5;
   assign aw_addr  = req_addr;
   assign w_data   = req_data;
   assign aw_valid = req & ~aw_done;
   assign w_valid  = req & ~w_done;
   assign busy     = run & (state != IDLE);
   assign poll_inc = (poll_cnt == 16'hffff) ? poll_cnt
                                            : poll_cnt + 16'd1;

   // Next state, handshake outputs and the active write's addr/data
   always_comb begin
      state_n  = state;
      ret_n    = ret;
      req      = 1'b0;
      req_addr = 3'd0;
      req_data = 8'h00;
      in_ready = 1'b0;
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      b_ready  = 1'b0;
      err_set  = 1'b0;
      if (run) begin
         unique case (state)
            INIT0: begin
               req      = 1'b1;
               req_addr = 3'd3;
               req_data = 8'h80;
               ret_n    = INIT1;
            end
            INIT1: begin
               req      = 1'b1;
               req_addr = 3'd0;
               req_data = DIVISOR[7:0];
               ret_n    = INIT2;
            end
            INIT2: begin
               req      = 1'b1;
               req_addr = 3'd1;
               req_data = DIVISOR[15:8];
               ret_n    = INIT3;
            end
            INIT3: begin
               req      = 1'b1;
               req_addr = 3'd3;
               req_data = LCR_VALUE;
               ret_n    = IDLE;
            end
            WR_REQ: begin
               req      = 1'b1;
               req_addr = 3'd0;
               req_data = tx_byte;
               ret_n    = IDLE;
            end
            WR_RESP: begin
               b_ready = 1'b1;
               if (b_valid) begin
                  state_n = ret;
                  err_set = (b_resp != 2'b00);
               end
            end
            IDLE: begin
               in_ready = 1'b1;
               if (in_valid) state_n = POLL_AR;
            end
            POLL_AR: begin
               ar_valid = 1'b1;
               if (ar_ready) state_n = POLL_R;
            end
            POLL_R: begin
               r_ready = 1'b1;
               if (r_valid) begin
                  err_set = (r_resp != 2'b00);
                  if (r_data[5]) begin
                     state_n = WR_REQ;
                  end else if (UNLIMITED || poll_inc < PMAX) begin
                     state_n = POLL_AR;
                  end else begin
                     err_set = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
            default: state_n = INIT0;
         endcase
         if (req && (aw_done || aw_ready) && (w_done || w_ready))
            state_n = WR_RESP;
      end
   end

   // State register; run keeps every output quiet while rst is held
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT0;
         ret   <= INIT0;
         run   <= 1'b0;
      end else begin
         state <= state_n;
         ret   <= ret_n;
         run   <= 1'b1;
      end
   end

   // Write completion flags, latched byte, poll counter, sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         tx_byte   <= 8'h00;
         poll_cnt  <= 16'd0;
         err       <= 1'b0;
         init_done <= 1'b0;
      end else begin
         if (state_n != state) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_valid && aw_ready) aw_done <= 1'b1;
            if (w_valid && w_ready) w_done <= 1'b1;
         end
         if (in_valid && in_ready) begin
            tx_byte  <= in_data;
            poll_cnt <= 16'd0;
         end else if (r_valid && r_ready) begin
            poll_cnt <= poll_inc;
         end
         if (err_set) err <= 1'b1;
         if (state_n == IDLE) init_done <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart16550_nasti_master.sv
// Bench for uart16550_nasti_master: two instances (unlimited / 4 polls)
// against a transaction-level model and a randomised register slave.
module tb_uart16550_nasti_master;
   localparam int NI = 2;

   logic       clk = 1'b0;
   logic       rst [NI];
   logic [7:0] in_data [NI];
   logic       in_valid [NI], in_ready [NI];
   logic       init_done [NI], busy [NI], err [NI];
   logic [2:0] aw_addr [NI];
   logic       aw_valid [NI], aw_ready [NI];
   logic [7:0] w_data [NI];
   logic       w_valid [NI], w_ready [NI];
   logic [1:0] b_resp [NI];
   logic       b_valid [NI], b_ready [NI];
   logic [2:0] ar_addr [NI];
   logic       ar_valid [NI], ar_ready [NI];
   logic [1:0] r_resp [NI];
   logic [7:0] r_data [NI];
   logic       r_valid [NI], r_ready [NI];

   uart16550_nasti_master #(.POLL_MAX(0)) dut0 (
      .clk(clk), .rst(rst[0]),
      .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .init_done(init_done[0]),
      .busy(busy[0]), .err(err[0]),
      .aw_addr(aw_addr[0]), .aw_valid(aw_valid[0]),
      .aw_ready(aw_ready[0]),
      .w_data(w_data[0]), .w_valid(w_valid[0]), .w_ready(w_ready[0]),
      .b_resp(b_resp[0]), .b_valid(b_valid[0]), .b_ready(b_ready[0]),
      .ar_addr(ar_addr[0]), .ar_valid(ar_valid[0]),
      .ar_ready(ar_ready[0]),
      .r_resp(r_resp[0]), .r_data(r_data[0]),
      .r_valid(r_valid[0]), .r_ready(r_ready[0]));

   uart16550_nasti_master #(.POLL_MAX(4)) dut1 (
      .clk(clk), .rst(rst[1]),
      .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .init_done(init_done[1]),
      .busy(busy[1]), .err(err[1]),
      .aw_addr(aw_addr[1]), .aw_valid(aw_valid[1]),
      .aw_ready(aw_ready[1]),
      .w_data(w_data[1]), .w_valid(w_valid[1]), .w_ready(w_ready[1]),
      .b_resp(b_resp[1]), .b_valid(b_valid[1]), .b_ready(b_ready[1]),
      .ar_addr(ar_addr[1]), .ar_valid(ar_valid[1]),
      .ar_ready(ar_ready[1]),
      .r_resp(r_resp[1]), .r_data(r_data[1]),
      .r_valid(r_valid[1]), .r_ready(r_ready[1]));

   always #5 clk = ~clk;

   // model: pending writes {addr,data}, stream source, LSR script, log
   logic [10:0] wq [NI][$];
   logic [10:0] obs [NI][$];
   logic [7:0]  srcq [NI][$];
   logic [7:0]  lsrq [NI][$];
   int          pmax [NI];
   bit          known;
   bit          in_rst [NI], aw_got [NI], w_got [NI];
   bit          rd_ar [NI], rd_r [NI], err_e [NI];
   bit          lsr_zero [NI], rerr_en [NI];
   int          init_left [NI], polls [NI], nreads [NI], wcount [NI];
   int          berr_idx [NI], fix_aw [NI], fix_w [NI], fix_ar [NI];
   int          aw_lat [NI], w_lat [NI], ar_lat [NI];
   int          b_lat [NI], r_lat [NI];
   int          aw_vc [NI], w_vc [NI], ar_vc [NI], b_wt [NI], r_wt [NI];
   int          last_aw_vc [NI], last_w_vc [NI];
   logic [7:0]  cur [NI], r_d [NI], cap_d [NI];
   logic [2:0]  cap_a [NI];
   logic [1:0]  b_r [NI], r_r [NI];
   int          n_chk, n_fail;

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] t=%0t: got %0h want %0h",
                  nm, k, $time, act, exp);
      end
   endtask

   function automatic int lat(input int fix);
      return (fix >= 0) ? fix : int'($urandom_range(0, 2));
   endfunction

   function automatic bit m_idle(input int k);
      return !in_rst[k] && wq[k].size() == 0 && !rd_ar[k] && !rd_r[k];
   endfunction

   function automatic logic [7:0] lsr_pick(input int k);
      logic [7:0] v;
      v = 8'($urandom);
      if (lsr_zero[k]) return 8'h00;
      if (lsrq[k].size() > 0) return lsrq[k].pop_front();
      return ($urandom_range(0, 3) == 0) ? (v | 8'h20) : (v & 8'hdf);
   endfunction

   task automatic step(input int k);
      bit idle, ih, ah, wh, bh, arh, rh, pend;
      idle = m_idle(k);
      if (known && in_rst[k]) begin
         chk("rst_aw_valid", k, aw_valid[k], 0);
         chk("rst_w_valid", k, w_valid[k], 0);
         chk("rst_b_ready", k, b_ready[k], 0);
         chk("rst_ar_valid", k, ar_valid[k], 0);
         chk("rst_r_ready", k, r_ready[k], 0);
         chk("rst_in_ready", k, in_ready[k], 0);
         chk("rst_init_done", k, init_done[k], 0);
         chk("rst_err", k, err[k], 0);
      end else if (known) begin
         pend = wq[k].size() > 0;
         chk("aw_valid", k, aw_valid[k], pend && !aw_got[k]);
         chk("w_valid", k, w_valid[k], pend && !w_got[k]);
         chk("b_ready", k, b_ready[k], pend && aw_got[k] && w_got[k]);
         chk("ar_valid", k, ar_valid[k], rd_ar[k]);
         chk("r_ready", k, r_ready[k], rd_r[k]);
         chk("in_ready", k, in_ready[k], idle);
         chk("busy", k, busy[k], !idle);
         chk("init_done", k, init_done[k], init_left[k] == 0);
         chk("err", k, err[k], err_e[k]);
         if (aw_valid[k] && pend)
            chk("aw_addr", k, aw_addr[k], wq[k][0][10:8]);
         if (w_valid[k] && pend)
            chk("w_data", k, w_data[k], wq[k][0][7:0]);
         if (ar_valid[k]) chk("ar_addr", k, ar_addr[k], 5);
      end
      if (rst[k]) begin
         in_rst[k] = 1; wq[k].delete();
         aw_got[k] = 0; w_got[k] = 0; rd_ar[k] = 0; rd_r[k] = 0;
         err_e[k] = 0; init_left[k] = 4; wcount[k] = 0;
         aw_vc[k] = 0; w_vc[k] = 0; ar_vc[k] = 0;
         b_wt[k] = 0; r_wt[k] = 0;
         in_valid[k] = 0; aw_ready[k] = 0; w_ready[k] = 0;
         b_valid[k] = 0; b_resp[k] = 0; ar_ready[k] = 0;
         r_valid[k] = 0; r_resp[k] = 0; r_data[k] = 0;
         return;
      end
      if (in_rst[k]) begin
         in_rst[k] = 0;
         wq[k].push_back({3'd3, 8'h80});
         wq[k].push_back({3'd0, 8'hde});
         wq[k].push_back({3'd1, 8'had});
         wq[k].push_back({3'd3, 8'h03});
      end
      if (aw_valid[k] && aw_vc[k] == 0) aw_lat[k] = lat(fix_aw[k]);
      if (w_valid[k] && w_vc[k] == 0) w_lat[k] = lat(fix_w[k]);
      if (ar_valid[k] && ar_vc[k] == 0) ar_lat[k] = lat(fix_ar[k]);
      in_valid[k] = srcq[k].size() > 0;
      in_data[k] = (srcq[k].size() > 0) ? srcq[k][0] : 8'h00;
      aw_ready[k] = aw_valid[k] && aw_vc[k] >= aw_lat[k];
      w_ready[k] = w_valid[k] && w_vc[k] >= w_lat[k];
      ar_ready[k] = ar_valid[k] && ar_vc[k] >= ar_lat[k];
      b_valid[k] = aw_got[k] && w_got[k] && b_wt[k] >= b_lat[k];
      b_resp[k] = b_valid[k] ? b_r[k] : 2'b00;
      r_valid[k] = rd_r[k] && r_wt[k] >= r_lat[k];
      r_data[k] = r_valid[k] ? r_d[k] : 8'h00;
      r_resp[k] = r_valid[k] ? r_r[k] : 2'b00;
      ih = in_valid[k] && in_ready[k];
      ah = aw_valid[k] && aw_ready[k];
      wh = w_valid[k] && w_ready[k];
      bh = b_valid[k] && b_ready[k];
      arh = ar_valid[k] && ar_ready[k];
      rh = r_valid[k] && r_ready[k];
      if (aw_valid[k]) aw_vc[k]++;
      if (w_valid[k]) w_vc[k]++;
      if (ar_valid[k]) ar_vc[k]++;
      if (aw_got[k] && w_got[k]) b_wt[k]++;
      if (rd_r[k]) r_wt[k]++;
      if (ih) begin
         cur[k] = srcq[k].pop_front();
         polls[k] = 0;
         rd_ar[k] = 1;
      end
      if (arh) begin
         rd_ar[k] = 0; rd_r[k] = 1; ar_vc[k] = 0; nreads[k]++;
         r_wt[k] = 0; r_lat[k] = lat(-1);
         r_d[k] = lsr_pick(k);
         r_r[k] = (rerr_en[k] && $urandom_range(0, 15) == 0) ? 2'b10
                                                             : 2'b00;
      end
      if (rh) begin
         rd_r[k] = 0; polls[k]++;
         if (r_r[k] != 2'b00) err_e[k] = 1;
         if (r_d[k][5]) wq[k].push_back({3'd0, cur[k]});
         else if (pmax[k] != 0 && polls[k] >= pmax[k]) err_e[k] = 1;
         else rd_ar[k] = 1;
      end
      if (bh) begin
         if (b_r[k] != 2'b00) err_e[k] = 1;
         obs[k].push_back({cap_a[k], cap_d[k]});
         if (wq[k].size() > 0) void'(wq[k].pop_front());
         aw_got[k] = 0; w_got[k] = 0; wcount[k]++;
         if (init_left[k] > 0) init_left[k]--;
      end
      if (ah) begin
         aw_got[k] = 1; cap_a[k] = aw_addr[k];
         last_aw_vc[k] = aw_vc[k]; aw_vc[k] = 0;
      end
      if (wh) begin
         w_got[k] = 1; cap_d[k] = w_data[k];
         last_w_vc[k] = w_vc[k]; w_vc[k] = 0;
      end
      if ((ah || wh) && aw_got[k] && w_got[k]) begin
         b_r[k] = (wcount[k] == berr_idx[k]) ? 2'b10 : 2'b00;
         b_wt[k] = 0; b_lat[k] = lat(-1);
      end
   endtask

   // single compare/slave process, working at the falling edge
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) step(k);
         known = 1;
      end
   end

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!(m_idle(k) && srcq[k].size() == 0) && n < 3000);
      chk("idle_timeout", k, n < 3000, 1);
   endtask

   task automatic chk_obs(input string nm, input int k, input int i,
                          input logic [10:0] exp);
      if (obs[k].size() > i) chk(nm, k, obs[k][i], exp);
      else chk({nm, "_missing"}, k, obs[k].size(), i + 1);
   endtask

   task automatic send(input int k, input logic [7:0] b);
      nreads[k] = 0;
      obs[k].delete();
      srcq[k].push_back(b);
      wait_idle(k);
   endtask

   initial begin
      int n;
      n_chk = 0; n_fail = 0; known = 0;
      pmax[0] = 0; pmax[1] = 4;
      for (int k = 0; k < NI; k++) begin
         rst[k] = 1; fix_aw[k] = -1; fix_w[k] = -1; fix_ar[k] = -1;
         berr_idx[k] = -1; lsr_zero[k] = 0; rerr_en[k] = 0;
         in_valid[k] = 0; in_data[k] = 0; aw_ready[k] = 0;
         w_ready[k] = 0; b_valid[k] = 0; b_resp[k] = 0;
         ar_ready[k] = 0; r_valid[k] = 0; r_resp[k] = 0; r_data[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_aw_valid", 0, aw_valid[0], 0);
      chk("reset_in_ready", 0, in_ready[0], 0);
      rst[0] = 0; rst[1] = 0;
      wait_idle(0); wait_idle(1);
      for (int k = 0; k < NI; k++) begin
         chk("init_cnt", k, obs[k].size(), 4);
         chk_obs("init_w0", k, 0, {3'd3, 8'h80});
         chk_obs("init_w1", k, 1, {3'd0, 8'hde});
         chk_obs("init_w2", k, 2, {3'd1, 8'had});
         chk_obs("init_w3", k, 3, {3'd3, 8'h03});
         chk("init_done_lit", k, init_done[k], 1);
         chk("init_busy_lit", k, busy[k], 0);
         chk("init_in_ready_lit", k, in_ready[k], 1);
      end
      lsrq[0].push_back(8'h60);
      send(0, 8'h48);
      chk("b48_reads", 0, nreads[0], 1);
      chk_obs("b48_thr", 0, 0, {3'd0, 8'h48});
      lsrq[0].push_back(8'h60);
      send(0, 8'h65);
      chk_obs("b65_thr", 0, 0, {3'd0, 8'h65});
      lsrq[0].push_back(8'h00); lsrq[0].push_back(8'h00);
      lsrq[0].push_back(8'h20);
      send(0, 8'h5a);
      chk("poll3_reads", 0, nreads[0], 3);
      chk_obs("poll3_thr", 0, 0, {3'd0, 8'h5a});
      chk("poll3_err", 0, err[0], 0);
      fix_aw[0] = 3; fix_w[0] = 0;
      lsrq[0].push_back(8'h20);
      send(0, 8'h33);
      chk("slow_aw_cycles", 0, last_aw_vc[0], 4);
      chk("slow_w_cycles", 0, last_w_vc[0], 1);
      chk("slow_b_count", 0, obs[0].size(), 1);
      chk_obs("slow_thr", 0, 0, {3'd0, 8'h33});
      fix_aw[0] = -1; fix_w[0] = -1;
      lsr_zero[1] = 1;
      send(1, 8'h77);
      chk("tmo_reads", 1, nreads[1], 4);
      chk("tmo_err", 1, err[1], 1);
      chk("tmo_no_thr", 1, obs[1].size(), 0);
      chk("tmo_in_ready", 1, in_ready[1], 1);
      lsr_zero[1] = 0;
      lsrq[1].push_back(8'h20);
      send(1, 8'h78);
      chk_obs("after_tmo_thr", 1, 0, {3'd0, 8'h78});
      chk("after_tmo_err", 1, err[1], 1);
      berr_idx[0] = 2;
      obs[0].delete();
      rst[0] = 1;
      @(posedge clk); #1;
      rst[0] = 0;
      wait_idle(0);
      berr_idx[0] = -1;
      chk("berr_err", 0, err[0], 1);
      chk("berr_cnt", 0, obs[0].size(), 4);
      chk_obs("berr_w3", 0, 3, {3'd3, 8'h03});
      fix_ar[0] = 5;
      srcq[0].push_back(8'h99);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ar_valid[0] && n < 100);
      chk("ar_wait_timeout", 0, n < 100, 1);
      rst[0] = 1;
      obs[0].delete();
      @(posedge clk); #1;
      chk("midrst_ar_valid", 0, ar_valid[0], 0);
      chk("midrst_aw_valid", 0, aw_valid[0], 0);
      chk("midrst_w_valid", 0, w_valid[0], 0);
      rst[0] = 0;
      fix_ar[0] = -1;
      @(posedge clk); #1;
      chk("restart_aw_valid", 0, aw_valid[0], 1);
      chk("restart_aw_addr", 0, aw_addr[0], 3);
      chk("restart_w_data", 0, w_data[0], 8'h80);
      wait_idle(0);
      chk_obs("restart_w0", 0, 0, {3'd3, 8'h80});
      chk("restart_err", 0, err[0], 0);
      for (int k = 0; k < NI; k++) begin
         rerr_en[k] = 1;
         for (int i = 0; i < 30; i++) srcq[k].push_back(8'($urandom));
      end
      wait_idle(0); wait_idle(1);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
